// File: rtl/instr_pkg.sv
// Shared definitions for the calculator instruction word: key codes, encoder
// states, field positions and operation codes. Used by encoder and decoder.
package instr_pkg;

    localparam int IMM_W_DEF   = 16;
    localparam int FUNCT_W_DEF = 3;
    localparam int INSTR_W_DEF = 2*IMM_W_DEF + FUNCT_W_DEF;

    localparam logic [4:0] KEY_DIGIT_MAX = 5'h09;
    localparam logic [4:0] KEY_OP_BASE   = 5'h10;
    localparam logic [4:0] KEY_ENTER     = 5'h18;
    localparam logic [4:0] KEY_CLEAR     = 5'h19;

    typedef enum logic [1:0] {
        S_OPA  = 2'd0,
        S_OPB  = 2'd1,
        S_EMIT = 2'd2
    } enc_state_e;

    // {immA, immB, funct}, MSB first
    localparam int IMMA_MSB  = 34;
    localparam int IMMA_LSB  = 19;
    localparam int IMMB_MSB  = 18;
    localparam int IMMB_LSB  = 3;
    localparam int FUNCT_MSB = 2;
    localparam int FUNCT_LSB = 0;

    localparam logic [2:0] FUNCT_ADD = 3'd0;
    localparam logic [2:0] FUNCT_SUB = 3'd1;
    localparam logic [2:0] FUNCT_MUL = 3'd2;
    localparam logic [2:0] FUNCT_DIV = 3'd3;
    localparam logic [2:0] FUNCT_AND = 3'd4;
    localparam logic [2:0] FUNCT_OR  = 3'd5;
    localparam logic [2:0] FUNCT_XOR = 3'd6;
    localparam logic [2:0] FUNCT_MOD = 3'd7;

    function automatic logic key_is_digit(input logic [4:0] code);
        return code <= KEY_DIGIT_MAX;
    endfunction

    function automatic logic key_is_op(input logic [4:0] code);
        return code[4:3] == KEY_OP_BASE[4:3];
    endfunction

endpackage

// File: rtl/decimal_accumulator.sv
// Combinational value*10+digit with overflow detect; shared by both operands.
module decimal_accumulator #(
    parameter int IMM_W = 16
) (
    input  logic [IMM_W-1:0] i_value,
    input  logic [3:0]       i_digit,
    output logic [IMM_W-1:0] o_result,
    output logic             o_overflow
);

    logic [IMM_W+3:0] w_wide;
    logic [IMM_W+3:0] w_sum;

    assign w_wide = {4'b0, i_value};
    // x10 as shift-add; 4 guard bits hold the full 10*max+9 result
    assign w_sum      = (w_wide << 3) + (w_wide << 1) + {{IMM_W{1'b0}}, i_digit};
    assign o_result   = w_sum[IMM_W-1:0];
    assign o_overflow = |w_sum[IMM_W+3:IMM_W];

endmodule

// File: rtl/instruction_encoder.sv
// Keypad-to-instruction encoder: collects operand A, operator, operand B and
// presents {immA, immB, funct} on a valid/ready handshake after ENTER.
module instruction_encoder
    import instr_pkg::*;
#(
    parameter int IMM_W   = IMM_W_DEF,
    parameter int FUNCT_W = FUNCT_W_DEF,
    localparam int INSTR_W = 2*IMM_W + FUNCT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               key_valid,
    input  logic [4:0]         key_code,
    output logic               key_ready,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [IMM_W-1:0]   disp_value,
    output logic               err
);

    enc_state_e         r_state;
    logic [IMM_W-1:0]   r_imm_a;
    logic [IMM_W-1:0]   r_imm_b;
    logic [FUNCT_W-1:0] r_funct;
    logic               r_err;

    logic [IMM_W-1:0]   w_acc_in;
    logic [IMM_W-1:0]   w_acc_out;
    logic               w_acc_ovf;
    logic               w_key_fire;
    logic               w_is_digit;
    logic               w_is_op;

    assign w_key_fire = key_valid && key_ready;
    assign w_is_digit = key_is_digit(key_code);
    assign w_is_op    = key_is_op(key_code);
    assign w_acc_in   = (r_state == S_OPA) ? r_imm_a : r_imm_b;

    decimal_accumulator #(.IMM_W(IMM_W)) u_acc (
        .i_value    (w_acc_in),
        .i_digit    (key_code[3:0]),
        .o_result   (w_acc_out),
        .o_overflow (w_acc_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_OPA;
            r_imm_a <= '0;
            r_imm_b <= '0;
            r_funct <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_OPA, S_OPB: begin
                    if (w_key_fire) begin
                        if (w_is_digit) begin
                            if (w_acc_ovf)
                                r_err <= 1'b1;
                            else if (r_state == S_OPA)
                                r_imm_a <= w_acc_out;
                            else
                                r_imm_b <= w_acc_out;
                        end else if (w_is_op) begin
                            r_funct <= FUNCT_W'(key_code[2:0]);
                            r_state <= S_OPB;
                        end else if (key_code == KEY_ENTER) begin
                            if (r_state == S_OPB)
                                r_state <= S_EMIT;
                        end else if (key_code == KEY_CLEAR) begin
                            r_state <= S_OPA;
                            r_imm_a <= '0;
                            r_imm_b <= '0;
                            r_funct <= '0;
                            r_err   <= 1'b0;
                        end
                    end
                end
                S_EMIT: begin
                    // err survives a completed instruction; only CLEAR/reset drop it
                    if (instr_ready) begin
                        r_state <= S_OPA;
                        r_imm_a <= '0;
                        r_imm_b <= '0;
                        r_funct <= '0;
                    end
                end
                default: r_state <= S_OPA;
            endcase
        end
    end

    assign key_ready   = (r_state != S_EMIT);
    assign instr_valid = (r_state == S_EMIT);
    assign instruction = {r_imm_a, r_imm_b, r_funct};
    assign disp_value  = (r_state == S_OPA) ? r_imm_a : r_imm_b;
    assign err         = r_err;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed checks for instruction_encoder: entry, backpressure, overflow,
// operator overwrite, CLEAR, unused keys and async reset during EMIT.
module tb_instruction_encoder;

    logic        clk;
    logic        reset_n;
    logic        key_valid;
    logic [4:0]  key_code;
    logic        key_ready;
    logic        instr_valid;
    logic        instr_ready;
    logic [34:0] instruction;
    logic [15:0] disp_value;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;

    instruction_encoder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .disp_value  (disp_value),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drive at negedge, accepted at posedge, returns at the following negedge
    task automatic press(input logic [4:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 5'h1F;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #12;
        n_total++; if (key_ready !== 1'b1) $display("FAIL reset_key_ready got %b want 1", key_ready); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL reset_instr_valid got %b want 0", instr_valid); else n_pass++;
        n_total++; if (instruction !== 35'd0) $display("FAIL reset_instruction got %h want 0", instruction); else n_pass++;
        n_total++; if (disp_value !== 16'd0) $display("FAIL reset_disp got %0d want 0", disp_value); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic;
        instr_ready = 1'b1;
        press(5'h01); press(5'h02);
        n_total++; if (disp_value !== 16'd12) $display("FAIL basic_dispA got %0d want 12", disp_value); else n_pass++;
        press(5'h11); press(5'h03); press(5'h04);
        n_total++; if (disp_value !== 16'd34) $display("FAIL basic_dispB got %0d want 34", disp_value); else n_pass++;
        press(5'h18);
        n_total++; if (instr_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", instr_valid); else n_pass++;
        n_total++; if (instruction !== {16'd12, 16'd34, 3'd1}) $display("FAIL basic_instr got %h want %h", instruction, {16'd12, 16'd34, 3'd1}); else n_pass++;
        n_total++; if (key_ready !== 1'b0) $display("FAIL basic_key_ready got %b want 0", key_ready); else n_pass++;
        @(negedge clk);
        n_total++; if (instr_valid !== 1'b0) $display("FAIL basic_valid_drop got %b want 0", instr_valid); else n_pass++;
        n_total++; if (instruction !== 35'd0) $display("FAIL basic_cleared got %h want 0", instruction); else n_pass++;
        n_total++; if (key_ready !== 1'b1) $display("FAIL basic_ready_back got %b want 1", key_ready); else n_pass++;
    endtask

    task automatic test_back_to_back_hold;
        instr_ready = 1'b0;
        press(5'h01); press(5'h02); press(5'h11); press(5'h03); press(5'h04); press(5'h18);
        for (int i = 0; i < 5; i++) begin
            key_valid = 1'b1;
            key_code  = 5'h07;
            n_total++; if (instr_valid !== 1'b1) $display("FAIL hold_valid[%0d] got %b want 1", i, instr_valid); else n_pass++;
            n_total++; if (instruction !== {16'd12, 16'd34, 3'd1}) $display("FAIL hold_instr[%0d] got %h want %h", i, instruction, {16'd12, 16'd34, 3'd1}); else n_pass++;
            n_total++; if (key_ready !== 1'b0) $display("FAIL hold_key_ready[%0d] got %b want 0", i, key_ready); else n_pass++;
            @(negedge clk);
        end
        instr_ready = 1'b1;
        n_total++; if (disp_value !== 16'd34) $display("FAIL hold_disp got %0d want 34", disp_value); else n_pass++;
        @(negedge clk);
        key_valid = 1'b0;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL hold_accept got %b want 0", instr_valid); else n_pass++;
        n_total++; if (disp_value !== 16'd0) $display("FAIL hold_dropped_digit got %0d want 0", disp_value); else n_pass++;
    endtask

    task automatic test_overflow;
        press(5'h06); press(5'h05); press(5'h05); press(5'h03);
        n_total++; if (disp_value !== 16'd6553) $display("FAIL ovf_pre got %0d want 6553", disp_value); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL ovf_pre_err got %b want 0", err); else n_pass++;
        press(5'h06);
        n_total++; if (disp_value !== 16'd6553) $display("FAIL ovf_hold got %0d want 6553", disp_value); else n_pass++;
        n_total++; if (err !== 1'b1) $display("FAIL ovf_err got %b want 1", err); else n_pass++;
        press(5'h02);
        n_total++; if (err !== 1'b1) $display("FAIL ovf_sticky got %b want 1", err); else n_pass++;
        press(5'h19);
        n_total++; if (err !== 1'b0) $display("FAIL ovf_clear_err got %b want 0", err); else n_pass++;
        press(5'h06); press(5'h05); press(5'h05); press(5'h03); press(5'h05);
        n_total++; if (disp_value !== 16'd65535) $display("FAIL max_value got %0d want 65535", disp_value); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL max_err got %b want 0", err); else n_pass++;
        press(5'h19);
    endtask

    task automatic test_op_overwrite;
        instr_ready = 1'b1;
        press(5'h18);
        n_total++; if (instr_valid !== 1'b0) $display("FAIL enter_opa_valid got %b want 0", instr_valid); else n_pass++;
        press(5'h07);
        n_total++; if (disp_value !== 16'd7) $display("FAIL enter_opa_disp got %0d want 7", disp_value); else n_pass++;
        press(5'h12); press(5'h15); press(5'h18);
        n_total++; if (instruction !== {16'd7, 16'd0, 3'd5}) $display("FAIL op_last_wins got %h want %h", instruction, {16'd7, 16'd0, 3'd5}); else n_pass++;
        n_total++; if (instr_valid !== 1'b1) $display("FAIL op_valid got %b want 1", instr_valid); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_clear;
        press(5'h09); press(5'h10); press(5'h04);
        n_total++; if (instruction !== {16'd9, 16'd4, 3'd0}) $display("FAIL clear_pre got %h want %h", instruction, {16'd9, 16'd4, 3'd0}); else n_pass++;
        press(5'h19);
        n_total++; if (instruction !== 35'd0) $display("FAIL clear_regs got %h want 0", instruction); else n_pass++;
        n_total++; if (disp_value !== 16'd0) $display("FAIL clear_disp got %0d want 0", disp_value); else n_pass++;
        press(5'h03);
        // digit lands in immA, proving CLEAR returned to S_OPA
        n_total++; if (instruction !== {16'd3, 16'd0, 3'd0}) $display("FAIL clear_state got %h want %h", instruction, {16'd3, 16'd0, 3'd0}); else n_pass++;
        press(5'h0B); press(5'h1C);
        n_total++; if (instruction !== {16'd3, 16'd0, 3'd0}) $display("FAIL unused_keys got %h want %h", instruction, {16'd3, 16'd0, 3'd0}); else n_pass++;
        press(5'h19);
    endtask

    task automatic test_reset_emit;
        instr_ready = 1'b0;
        press(5'h01); press(5'h13); press(5'h02); press(5'h18);
        n_total++; if (instr_valid !== 1'b1) $display("FAIL rst_emit_pre got %b want 1", instr_valid); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL rst_async_valid got %b want 0", instr_valid); else n_pass++;
        n_total++; if (key_ready !== 1'b1) $display("FAIL rst_async_ready got %b want 1", key_ready); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_total++; if (instruction !== 35'd0) $display("FAIL rst_after_instr got %h want 0", instruction); else n_pass++;
        n_total++; if (disp_value !== 16'd0 || err !== 1'b0 || instr_valid !== 1'b0) $display("FAIL rst_after_outs got disp=%0d err=%b valid=%b want 0/0/0", disp_value, err, instr_valid); else n_pass++;
        press(5'h05);
        n_total++; if (disp_value !== 16'd5) $display("FAIL rst_after_opa got %0d want 5", disp_value); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

    initial begin
        key_valid   = 1'b0;
        key_code    = 5'h1F;
        instr_ready = 1'b0;
        reset_n     = 1'b1;
        test_reset;
        test_basic;
        test_back_to_back_hold;
        test_overflow;
        test_op_overwrite;
        test_clear;
        test_reset_emit;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
